// File: rtl/img_rsz_blk_buf_gen_if.sv
// Pixel stream and compute-engine block bus of the resizer block buffer.
// The master side feeds pixels and picks blocks; the slave side is the buffer.
interface img_rsz_blk_buf_gen_if #(
    parameter int CH_NUM    = 3,
    parameter int CH_W      = 8,
    parameter int RSZ_W     = 4,
    parameter int RSZ_H     = 4,
    parameter int IMG_X_W   = 11,
    parameter int IMG_Y_W   = 11,
    parameter int BLK_CNT_W = 16
);
    localparam int SUM_W = CH_W + BLK_CNT_W;

    logic [CH_NUM*CH_W-1:0]  PxlData;
    logic [IMG_X_W-1:0]      PxlX;
    logic [IMG_Y_W-1:0]      PxlY;
    logic                    PxlVld;
    logic                    PxlRdy;
    logic [RSZ_W-1:0]        CompBlkXMsk;
    logic [RSZ_H-1:0]        CompBlkYMsk;
    logic                    CompBlkEn;
    logic [CH_NUM*SUM_W-1:0] CompBlkData;
    logic [BLK_CNT_W-1:0]    CompBlkCnt;
    logic [IMG_X_W-1:0]      CompBlkW;
    logic [IMG_Y_W-1:0]      CompBlkH;

    modport master (
        output PxlData, PxlX, PxlY, PxlVld, CompBlkXMsk, CompBlkYMsk, CompBlkEn,
        input  PxlRdy, CompBlkData, CompBlkCnt, CompBlkW, CompBlkH
    );

    modport slave (
        input  PxlData, PxlX, PxlY, PxlVld, CompBlkXMsk, CompBlkYMsk, CompBlkEn,
        output PxlRdy, CompBlkData, CompBlkCnt, CompBlkW, CompBlkH
    );
endinterface

// File: rtl/img_rsz_blk_buf_gen.sv
// Block buffer for the image resizer: splits an X x Y source image into
// RSZ_W x RSZ_H blocks whose boundaries are built at run time by a shared
// restoring divider, accumulates pixels per block (SUM/MAX/MIN) and hands
// one selected block at a time to the compute engine.
module img_rsz_blk_buf_gen #(
    parameter int CH_NUM    = 3,
    parameter int CH_W      = 8,
    parameter int RSZ_W     = 4,
    parameter int RSZ_H     = 4,
    parameter int IMG_X_W   = 11,
    parameter int IMG_Y_W   = 11,
    parameter int BLK_CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     CfgStart,
    input  logic [IMG_X_W-1:0]       ProcImgWidth,
    input  logic [IMG_Y_W-1:0]       ProcImgHeight,
    input  logic [1:0]               PoolMode,
    output logic                     CfgBusy,
    output logic                     CfgErr,
    output logic [RSZ_H*RSZ_W-1:0]   BlkIsEnough,
    img_rsz_blk_buf_gen_if.slave     blkIf
);
    localparam int SUM_W   = CH_W + BLK_CNT_W;
    localparam int NBLK    = RSZ_W * RSZ_H;
    localparam int DIV_W   = (IMG_X_W > IMG_Y_W) ? IMG_X_W : IMG_Y_W;
    localparam int RSZ_MAX = (RSZ_W > RSZ_H) ? RSZ_W : RSZ_H;
    localparam int REM_W   = $clog2(RSZ_MAX) + 1;
    localparam int STEP_W  = $clog2(DIV_W + RSZ_MAX + 1);

    typedef enum logic [2:0] {IDLE, DIV_X, TAB_X, DIV_Y, TAB_Y, READY} CfgStateT;

    CfgStateT state, stateNext;

    logic [IMG_Y_W-1:0] cfgY;
    logic [1:0]         cfgMode;
    logic               cfgErrReg;
    logic [DIV_W-1:0]   divDvd, divQ;
    logic [REM_W-1:0]   divRem, racc;
    logic [STEP_W-1:0]  stepCnt;
    logic [IMG_X_W-1:0] bx [RSZ_W+1];
    logic [IMG_Y_W-1:0] by [RSZ_H+1];

    logic [SUM_W-1:0]     acc [NBLK][CH_NUM];
    logic [BLK_CNT_W-1:0] cnt [NBLK];
    logic [NBLK-1:0]      enough;

    logic               cfgBad, inY, divGe, tabCarry, stepLast, pxlRdy, accept, selValid;
    logic [REM_W-1:0]   divisor, divShift, tabSum;
    logic [RSZ_W-1:0]   colHit, colLast;
    logic [RSZ_H-1:0]   rowHit, rowLast;
    logic [NBLK-1:0]    blkHit, blkClr, blkLast;
    logic [SUM_W-1:0]   pxlCh [CH_NUM];

    logic [CH_NUM*SUM_W-1:0] compData;
    logic [BLK_CNT_W-1:0]    compCnt;
    logic [IMG_X_W-1:0]      compW;
    logic [IMG_Y_W-1:0]      compH;

    function automatic logic [SUM_W-1:0] poolOp(input logic [1:0] mode,
                                                 input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] p);
        case (mode)
            2'd1:    poolOp = (p > a) ? p : a;
            2'd2:    poolOp = (p < a) ? p : a;
            default: poolOp = a + p;
        endcase
    endfunction

    assign cfgBad   = (ProcImgWidth < IMG_X_W'(RSZ_W)) || (ProcImgHeight < IMG_Y_W'(RSZ_H)) ||
                      (PoolMode == 2'd3);
    assign inY      = (state == DIV_Y) || (state == TAB_Y);
    assign divisor  = inY ? REM_W'(RSZ_H) : REM_W'(RSZ_W);
    assign divShift = {divRem[REM_W-2:0], divDvd[DIV_W-1]};
    assign divGe    = (divShift >= divisor);
    assign tabSum   = racc + divRem;
    assign tabCarry = (tabSum >= divisor);
    assign CfgBusy  = (state == DIV_X) || (state == TAB_X) || (state == DIV_Y) || (state == TAB_Y);
    assign CfgErr   = cfgErrReg;
    assign pxlRdy   = (state == READY) && !cfgErrReg;
    assign accept   = blkIf.PxlVld && pxlRdy;
    assign selValid = $onehot(blkIf.CompBlkXMsk) && $onehot(blkIf.CompBlkYMsk);

    assign blkIf.PxlRdy      = pxlRdy;
    assign blkIf.CompBlkData = compData;
    assign blkIf.CompBlkCnt  = compCnt;
    assign blkIf.CompBlkW    = compW;
    assign blkIf.CompBlkH    = compH;
    assign BlkIsEnough       = enough;

    // Detects the final step of each build phase so the FSM and step counter move on together.
    always_comb begin
        stepLast = 1'b0;
        case (state)
            DIV_X:   stepLast = (stepCnt == STEP_W'(IMG_X_W - 1));
            TAB_X:   stepLast = (stepCnt == STEP_W'(RSZ_W - 1));
            DIV_Y:   stepLast = (stepCnt == STEP_W'(IMG_Y_W - 1));
            TAB_Y:   stepLast = (stepCnt == STEP_W'(RSZ_H - 1));
            default: stepLast = 1'b0;
        endcase
    end

    // Config FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state: a CfgStart always restarts the build, or parks in IDLE if the config is bad.
    always_comb begin
        stateNext = state;
        if (CfgStart) begin
            stateNext = cfgBad ? IDLE : DIV_X;
        end else begin
            case (state)
                DIV_X:   if (stepLast) stateNext = TAB_X;
                TAB_X:   if (stepLast) stateNext = DIV_Y;
                DIV_Y:   if (stepLast) stateNext = TAB_Y;
                TAB_Y:   if (stepLast) stateNext = READY;
                default: stateNext = state;
            endcase
        end
    end

    // Shared divider and boundary-table builder; dividends are left-aligned so a phase takes its own width in cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cfgY      <= '0;
            cfgMode   <= '0;
            cfgErrReg <= 1'b0;
            divDvd    <= '0;
            divQ      <= '0;
            divRem    <= '0;
            racc      <= '0;
            stepCnt   <= '0;
            for (int i = 0; i <= RSZ_W; i++) bx[i] <= '0;
            for (int i = 0; i <= RSZ_H; i++) by[i] <= '0;
        end else if (CfgStart) begin
            cfgY      <= ProcImgHeight;
            cfgMode   <= PoolMode;
            cfgErrReg <= cfgBad;
            divDvd    <= DIV_W'(ProcImgWidth) << (DIV_W - IMG_X_W);
            divQ      <= '0;
            divRem    <= '0;
            racc      <= '0;
            stepCnt   <= '0;
        end else begin
            case (state)
                DIV_X, DIV_Y: begin
                    divDvd  <= divDvd << 1;
                    divQ    <= {divQ[DIV_W-2:0], divGe};
                    divRem  <= divGe ? (divShift - divisor) : divShift;
                    stepCnt <= stepLast ? '0 : stepCnt + STEP_W'(1);
                end
                TAB_X: begin
                    for (int i = 0; i < RSZ_W; i++)
                        if (stepCnt == STEP_W'(i))
                            bx[i+1] <= bx[i] + IMG_X_W'(divQ) + IMG_X_W'(tabCarry);
                    racc    <= tabCarry ? (tabSum - divisor) : tabSum;
                    stepCnt <= stepLast ? '0 : stepCnt + STEP_W'(1);
                    if (stepLast) begin
                        divDvd <= DIV_W'(cfgY) << (DIV_W - IMG_Y_W);
                        divQ   <= '0;
                        divRem <= '0;
                        racc   <= '0;
                    end
                end
                TAB_Y: begin
                    for (int i = 0; i < RSZ_H; i++)
                        if (stepCnt == STEP_W'(i))
                            by[i+1] <= by[i] + IMG_Y_W'(divQ) + IMG_Y_W'(tabCarry);
                    racc    <= tabCarry ? (tabSum - divisor) : tabSum;
                    stepCnt <= stepLast ? '0 : stepCnt + STEP_W'(1);
                end
                default: stepCnt <= '0;
            endcase
        end
    end

    // Decodes which block the incoming pixel lands in, whether it closes that block, and which block is being consumed.
    always_comb begin
        colHit  = '0;
        colLast = '0;
        rowHit  = '0;
        rowLast = '0;
        blkHit  = '0;
        blkClr  = '0;
        blkLast = '0;
        for (int c = 0; c < CH_NUM; c++) pxlCh[c] = SUM_W'(blkIf.PxlData[c*CH_W +: CH_W]);
        for (int u = 0; u < RSZ_W; u++) begin
            colHit[u]  = (blkIf.PxlX >= bx[u]) && (blkIf.PxlX < bx[u+1]);
            colLast[u] = (blkIf.PxlX == bx[u+1] - IMG_X_W'(1));
        end
        for (int v = 0; v < RSZ_H; v++) begin
            rowHit[v]  = (blkIf.PxlY >= by[v]) && (blkIf.PxlY < by[v+1]);
            rowLast[v] = (blkIf.PxlY == by[v+1] - IMG_Y_W'(1));
        end
        for (int v = 0; v < RSZ_H; v++) begin
            for (int u = 0; u < RSZ_W; u++) begin
                blkHit[v*RSZ_W+u]  = accept && colHit[u] && rowHit[v];
                blkLast[v*RSZ_W+u] = colLast[u] && rowLast[v];
                blkClr[v*RSZ_W+u]  = blkIf.CompBlkEn && selValid &&
                                     blkIf.CompBlkXMsk[u] && blkIf.CompBlkYMsk[v];
            end
        end
    end

    // Per-block accumulation; a consume on the same block wins and restarts it with the incoming pixel.
    always_ff @(posedge Clk) begin
        if (Reset || CfgStart) begin
            for (int b = 0; b < NBLK; b++) begin
                cnt[b]    <= '0;
                enough[b] <= 1'b0;
                for (int c = 0; c < CH_NUM; c++) acc[b][c] <= '0;
            end
        end else begin
            for (int b = 0; b < NBLK; b++) begin
                if (blkClr[b]) begin
                    enough[b] <= blkHit[b] && blkLast[b];
                    cnt[b]    <= blkHit[b] ? BLK_CNT_W'(1) : '0;
                    for (int c = 0; c < CH_NUM; c++) acc[b][c] <= blkHit[b] ? pxlCh[c] : '0;
                end else if (blkHit[b]) begin
                    if (blkLast[b]) enough[b] <= 1'b1;
                    if (cnt[b] != '1) cnt[b] <= cnt[b] + BLK_CNT_W'(1);
                    for (int c = 0; c < CH_NUM; c++)
                        acc[b][c] <= (cnt[b] == '0) ? pxlCh[c] : poolOp(cfgMode, acc[b][c], pxlCh[c]);
                end
            end
        end
    end

    // One-hot block select for the compute engine; anything but a clean one-hot pair reads as zero.
    always_comb begin
        compData = '0;
        compCnt  = '0;
        compW    = '0;
        compH    = '0;
        if (selValid) begin
            for (int v = 0; v < RSZ_H; v++) begin
                for (int u = 0; u < RSZ_W; u++) begin
                    if (blkIf.CompBlkXMsk[u] && blkIf.CompBlkYMsk[v]) begin
                        for (int c = 0; c < CH_NUM; c++) compData[c*SUM_W +: SUM_W] = acc[v*RSZ_W+u][c];
                        compCnt = cnt[v*RSZ_W+u];
                        compW   = bx[u+1] - bx[u];
                        compH   = by[v+1] - by[v];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_img_rsz_blk_buf_gen.sv
// Directed bench for the resizer block buffer: reset, table build,
// SUM/MAX/MIN accumulation, consume/accept collisions and config errors.
module tb_img_rsz_blk_buf_gen;
    localparam int CH_NUM    = 3;
    localparam int CH_W      = 8;
    localparam int RSZ_W     = 4;
    localparam int RSZ_H     = 4;
    localparam int IMG_X_W   = 11;
    localparam int IMG_Y_W   = 11;
    localparam int BLK_CNT_W = 16;
    localparam int SUM_W     = CH_W + BLK_CNT_W;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic                     CfgStart;
    logic [IMG_X_W-1:0]       ProcImgWidth;
    logic [IMG_Y_W-1:0]       ProcImgHeight;
    logic [1:0]               PoolMode;
    logic                     CfgBusy;
    logic                     CfgErr;
    logic [RSZ_H*RSZ_W-1:0]   BlkIsEnough;

    int total = 0;
    int bad   = 0;
    logic early00, early10;

    img_rsz_blk_buf_gen_if #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .RSZ_W(RSZ_W), .RSZ_H(RSZ_H),
        .IMG_X_W(IMG_X_W), .IMG_Y_W(IMG_Y_W), .BLK_CNT_W(BLK_CNT_W)
    ) bif ();

    img_rsz_blk_buf_gen #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .RSZ_W(RSZ_W), .RSZ_H(RSZ_H),
        .IMG_X_W(IMG_X_W), .IMG_Y_W(IMG_Y_W), .BLK_CNT_W(BLK_CNT_W)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .CfgStart(CfgStart),
        .ProcImgWidth(ProcImgWidth),
        .ProcImgHeight(ProcImgHeight),
        .PoolMode(PoolMode),
        .CfgBusy(CfgBusy),
        .CfgErr(CfgErr),
        .BlkIsEnough(BlkIsEnough),
        .blkIf(bif)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CH_NUM*SUM_W-1:0] triple(input int k);
        logic [SUM_W-1:0] s;
        s = SUM_W'(k);
        return {s, s, s};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic selBlk(input int u, input int v);
        bif.CompBlkXMsk = RSZ_W'(1) << u;
        bif.CompBlkYMsk = RSZ_H'(1) << v;
        @(negedge Clk);
    endtask

    task automatic startCfg(input int x, input int y, input int mode);
        ProcImgWidth  = IMG_X_W'(x);
        ProcImgHeight = IMG_Y_W'(y);
        PoolMode      = 2'(mode);
        CfgStart      = 1'b1;
        step();
        CfgStart      = 1'b0;
    endtask

    task automatic countBusy(input int want, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 100 && CfgBusy; i++) begin
            n++;
            step();
        end
        total++;
        if (n !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d busy cycles want %0d", name, n, want);
        end
    endtask

    task automatic waitReady(input string name);
        for (int i = 0; i < 100 && !bif.PxlRdy; i++) step();
        total++;
        if (bif.PxlRdy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s: got PxlRdy=%b want 1", name, bif.PxlRdy);
        end
    endtask

    task automatic drivePxl(input int x, input int y, input int val);
        logic [CH_W-1:0] d;
        d = CH_W'(val);
        bif.PxlX    = IMG_X_W'(x);
        bif.PxlY    = IMG_Y_W'(y);
        bif.PxlData = {d, d, d};
        bif.PxlVld  = 1'b1;
    endtask

    task automatic streamImage(input int w, input int h);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drivePxl(x, y, x + y);
                step();
                if (x == 0 && y == 0) early00 = BlkIsEnough[0];
                if (x == 1 && y == 0) early10 = BlkIsEnough[0];
            end
        end
        bif.PxlVld = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        CfgStart = 1'b0;
        ProcImgWidth = '0;
        ProcImgHeight = '0;
        PoolMode = '0;
        bif.PxlVld = 1'b0;
        bif.PxlX = '0;
        bif.PxlY = '0;
        bif.PxlData = '0;
        bif.CompBlkEn = 1'b0;
        bif.CompBlkXMsk = 4'b0001;
        bif.CompBlkYMsk = 4'b0001;
        step();
        step();
        total++; if (CfgBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", CfgBusy); end
        total++; if (CfgErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", CfgErr); end
        total++; if (bif.PxlRdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdy: got %b want 0", bif.PxlRdy); end
        total++; if (BlkIsEnough !== '0) begin bad++; $display("[TB] FAIL reset_enough: got %h want 0", BlkIsEnough); end
        total++; if (bif.CompBlkData !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bif.CompBlkData); end
        total++; if (bif.CompBlkW !== '0) begin bad++; $display("[TB] FAIL reset_w: got %0d want 0", bif.CompBlkW); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_config();
        int expW [RSZ_W];
        int expH [RSZ_H];
        expW = '{2, 3, 2, 3};
        expH = '{1, 2, 1, 2};
        startCfg(10, 6, 0);
        countBusy(30, "cfg_busy_len");
        total++; if (bif.PxlRdy !== 1'b1) begin bad++; $display("[TB] FAIL cfg_ready: got %b want 1", bif.PxlRdy); end
        for (int u = 0; u < RSZ_W; u++) begin
            selBlk(u, 0);
            total++;
            if (bif.CompBlkW !== IMG_X_W'(expW[u])) begin
                bad++; $display("[TB] FAIL cfg_w%0d: got %0d want %0d", u, bif.CompBlkW, expW[u]);
            end
        end
        for (int v = 0; v < RSZ_H; v++) begin
            selBlk(0, v);
            total++;
            if (bif.CompBlkH !== IMG_Y_W'(expH[v])) begin
                bad++; $display("[TB] FAIL cfg_h%0d: got %0d want %0d", v, bif.CompBlkH, expH[v]);
            end
        end
        bif.CompBlkXMsk = 4'b0011;
        bif.CompBlkYMsk = 4'b0001;
        @(negedge Clk);
        total++; if (bif.CompBlkW !== '0) begin bad++; $display("[TB] FAIL cfg_not_onehot: got %0d want 0", bif.CompBlkW); end
    endtask

    task automatic test_sum();
        streamImage(10, 6);
        drivePxl(10, 0, 50);
        step();
        drivePxl(0, 6, 50);
        step();
        bif.PxlVld = 1'b0;
        total++; if (early00 !== 1'b0) begin bad++; $display("[TB] FAIL sum_early00: got %b want 0", early00); end
        total++; if (early10 !== 1'b1) begin bad++; $display("[TB] FAIL sum_early10: got %b want 1", early10); end
        total++; if (BlkIsEnough !== 16'hFFFF) begin bad++; $display("[TB] FAIL sum_all_enough: got %h want ffff", BlkIsEnough); end
        selBlk(0, 0);
        total++; if (bif.CompBlkCnt !== 16'd2) begin bad++; $display("[TB] FAIL sum_cnt00: got %0d want 2", bif.CompBlkCnt); end
        total++; if (bif.CompBlkData !== triple(1)) begin bad++; $display("[TB] FAIL sum_data00: got %h want %h", bif.CompBlkData, triple(1)); end
        selBlk(1, 1);
        total++; if (bif.CompBlkCnt !== 16'd6) begin bad++; $display("[TB] FAIL sum_cnt11: got %0d want 6", bif.CompBlkCnt); end
        total++; if (bif.CompBlkData !== triple(27)) begin bad++; $display("[TB] FAIL sum_data11: got %h want %h", bif.CompBlkData, triple(27)); end
        selBlk(3, 0);
        total++; if (bif.CompBlkCnt !== 16'd3) begin bad++; $display("[TB] FAIL sum_cnt30: got %0d want 3", bif.CompBlkCnt); end
        total++; if (bif.CompBlkData !== triple(24)) begin bad++; $display("[TB] FAIL sum_data30: got %h want %h", bif.CompBlkData, triple(24)); end
        selBlk(3, 3);
        total++; if (bif.CompBlkData !== triple(75)) begin bad++; $display("[TB] FAIL sum_data33: got %h want %h", bif.CompBlkData, triple(75)); end
        selBlk(0, 0);
        bif.CompBlkEn = 1'b1;
        step();
        bif.CompBlkEn = 1'b0;
        total++; if (bif.CompBlkCnt !== '0) begin bad++; $display("[TB] FAIL consume_cnt: got %0d want 0", bif.CompBlkCnt); end
        total++; if (bif.CompBlkData !== '0) begin bad++; $display("[TB] FAIL consume_data: got %h want 0", bif.CompBlkData); end
        total++; if (BlkIsEnough !== 16'hFFFE) begin bad++; $display("[TB] FAIL consume_enough: got %h want fffe", BlkIsEnough); end
    endtask

    task automatic test_max_min();
        startCfg(10, 6, 1);
        total++; if (BlkIsEnough !== '0) begin bad++; $display("[TB] FAIL restart_clears: got %h want 0", BlkIsEnough); end
        waitReady("max_ready");
        streamImage(10, 6);
        selBlk(1, 1);
        total++; if (bif.CompBlkData !== triple(6)) begin bad++; $display("[TB] FAIL max_data11: got %h want %h", bif.CompBlkData, triple(6)); end
        total++; if (bif.CompBlkCnt !== 16'd6) begin bad++; $display("[TB] FAIL max_cnt11: got %0d want 6", bif.CompBlkCnt); end
        selBlk(0, 0);
        total++; if (bif.CompBlkData !== triple(1)) begin bad++; $display("[TB] FAIL max_data00: got %h want %h", bif.CompBlkData, triple(1)); end
        startCfg(10, 6, 2);
        waitReady("min_ready");
        streamImage(10, 6);
        selBlk(1, 1);
        total++; if (bif.CompBlkData !== triple(3)) begin bad++; $display("[TB] FAIL min_data11: got %h want %h", bif.CompBlkData, triple(3)); end
        total++; if (bif.CompBlkCnt !== 16'd6) begin bad++; $display("[TB] FAIL min_cnt11: got %0d want 6", bif.CompBlkCnt); end
        selBlk(0, 0);
        total++; if (bif.CompBlkData !== triple(0)) begin bad++; $display("[TB] FAIL min_data00: got %h want %h", bif.CompBlkData, triple(0)); end
    endtask

    task automatic test_simul_clear_accept();
        selBlk(0, 0);
        bif.CompBlkEn = 1'b1;
        drivePxl(0, 0, 9);
        step();
        bif.CompBlkEn = 1'b0;
        bif.PxlVld = 1'b0;
        total++; if (bif.CompBlkData !== triple(9)) begin bad++; $display("[TB] FAIL same_data: got %h want %h", bif.CompBlkData, triple(9)); end
        total++; if (bif.CompBlkCnt !== 16'd1) begin bad++; $display("[TB] FAIL same_cnt: got %0d want 1", bif.CompBlkCnt); end
        total++; if (BlkIsEnough[0] !== 1'b0) begin bad++; $display("[TB] FAIL same_enough: got %b want 0", BlkIsEnough[0]); end
        selBlk(3, 3);
        bif.CompBlkEn = 1'b1;
        drivePxl(1, 0, 4);
        step();
        bif.CompBlkEn = 1'b0;
        bif.PxlVld = 1'b0;
        total++; if (BlkIsEnough[15] !== 1'b0) begin bad++; $display("[TB] FAIL diff_enough33: got %b want 0", BlkIsEnough[15]); end
        total++; if (BlkIsEnough[0] !== 1'b1) begin bad++; $display("[TB] FAIL diff_enough00: got %b want 1", BlkIsEnough[0]); end
        total++; if (bif.CompBlkCnt !== '0) begin bad++; $display("[TB] FAIL diff_cnt33: got %0d want 0", bif.CompBlkCnt); end
        selBlk(0, 0);
        total++; if (bif.CompBlkData !== triple(4)) begin bad++; $display("[TB] FAIL diff_data00: got %h want %h", bif.CompBlkData, triple(4)); end
        total++; if (bif.CompBlkCnt !== 16'd2) begin bad++; $display("[TB] FAIL diff_cnt00: got %0d want 2", bif.CompBlkCnt); end
    endtask

    task automatic test_cfg_err();
        startCfg(3, 6, 0);
        total++; if (CfgErr !== 1'b1) begin bad++; $display("[TB] FAIL err_small_x: got %b want 1", CfgErr); end
        total++; if (bif.PxlRdy !== 1'b0) begin bad++; $display("[TB] FAIL err_rdy: got %b want 0", bif.PxlRdy); end
        total++; if (CfgBusy !== 1'b0) begin bad++; $display("[TB] FAIL err_busy: got %b want 0", CfgBusy); end
        startCfg(10, 6, 3);
        total++; if (CfgErr !== 1'b1) begin bad++; $display("[TB] FAIL err_mode3: got %b want 1", CfgErr); end
        total++; if (BlkIsEnough !== '0) begin bad++; $display("[TB] FAIL err_clears: got %h want 0", BlkIsEnough); end
        startCfg(8, 5, 0);
        total++; if (CfgErr !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared: got %b want 0", CfgErr); end
        total++; if (CfgBusy !== 1'b1) begin bad++; $display("[TB] FAIL err_rebuild_busy: got %b want 1", CfgBusy); end
        for (int i = 0; i < 12; i++) step();
        startCfg(12, 9, 0);
        countBusy(30, "restart_busy_len");
        total++; if (bif.PxlRdy !== 1'b1) begin bad++; $display("[TB] FAIL restart_ready: got %b want 1", bif.PxlRdy); end
        selBlk(0, 0);
        total++; if (bif.CompBlkW !== 11'd3) begin bad++; $display("[TB] FAIL restart_w0: got %0d want 3", bif.CompBlkW); end
        total++; if (bif.CompBlkH !== 11'd2) begin bad++; $display("[TB] FAIL restart_h0: got %0d want 2", bif.CompBlkH); end
        selBlk(3, 3);
        total++; if (bif.CompBlkW !== 11'd3) begin bad++; $display("[TB] FAIL restart_w3: got %0d want 3", bif.CompBlkW); end
        total++; if (bif.CompBlkH !== 11'd3) begin bad++; $display("[TB] FAIL restart_h3: got %0d want 3", bif.CompBlkH); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_sum();
        test_max_min();
        test_simul_clear_accept();
        test_cfg_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
